// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline control types for the RV32I core
package rv32i_types;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic id_ex_load;
        logic ex_mem_load;
        logic mem_wb_load;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic mem_stall;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_OFF      = 10'b00000_0000_0;
    localparam pipe_ctrl_t CTRL_STALL    = 10'b00000_0001_1;
    localparam pipe_ctrl_t CTRL_REDIRECT = 10'b11111_1100_0;
    localparam pipe_ctrl_t CTRL_BUBBLE   = 10'b00011_0100_0;
    localparam pipe_ctrl_t CTRL_NORMAL   = 10'b11111_0000_0;

    function automatic logic src_hit(input logic use_i, input logic [4:0] rs, input logic [4:0] rd);
        return use_i & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_perf_counters.sv
// rtl/pipe_perf_counters.sv - wrap-around stall/bubble/redirect event counters
import rv32i_types::*;

module pipe_perf_counters (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        bubble_i,
    input  logic        flush_i,
    output logic [31:0] perf_stall_cyc_o,
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_flush_o
);

    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q + {31'd0, stall_i};
        bubble_d    = bubble_q + {31'd0, bubble_i};
        flush_d     = flush_q + {31'd0, flush_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cyc_q <= '0;
            bubble_q    <= '0;
            flush_q     <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            bubble_q    <= bubble_d;
            flush_q     <= flush_d;
        end
    end

    assign perf_stall_cyc_o = stall_cyc_q;
    assign perf_bubble_o    = bubble_q;
    assign perf_flush_o     = flush_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the 5-stage pipeline (counters under PIPE_CTRL_PERF_EN)
import rv32i_types::*;

module pipeline_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        imem_read_i,
    input  logic        imem_resp_i,
    input  logic        dmem_access_i,
    input  logic        dmem_resp_i,
    input  logic        ex_redirect_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    output logic        pc_load_o,
    output logic        if_id_load_o,
    output logic        id_ex_load_o,
    output logic        ex_mem_load_o,
    output logic        mem_wb_load_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_flush_o,
    output logic        mem_stall_o,
    output logic [31:0] perf_stall_cyc_o,
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_flush_o
);

    pipe_state_e state_q, state_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        i_wait, d_wait, stall;
    logic        load_use, redirect, bubble;
    pipe_ctrl_t  ctrl;

    always_comb begin
        i_wait   = imem_read_i & ~imem_resp_i & ~i_done_q;
        d_wait   = dmem_access_i & ~dmem_resp_i & ~d_done_q;
        stall    = i_wait | d_wait;
        load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                   (src_hit(id_rs1_use_i, id_rs1_i, ex_rd_i) | src_hit(id_rs2_use_i, id_rs2_i, ex_rd_i));
        redirect = ~stall & ex_redirect_i;
        bubble   = ~stall & ~ex_redirect_i & load_use;

        // A side that already answered must not be waited on again; flags live only within one stall.
        i_done_d = stall & (i_done_q | imem_resp_i);
        d_done_d = stall & (d_done_q | dmem_resp_i);

        state_d = state_q;
        case (state_q)
            RUN:     if (stall)  state_d = STALL;
            STALL:   if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase

        ctrl = CTRL_NORMAL;
        if (!rst_ni)       ctrl = CTRL_OFF;
        else if (stall)    ctrl = CTRL_STALL;
        else if (redirect) ctrl = CTRL_REDIRECT;
        else if (bubble)   ctrl = CTRL_BUBBLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    assign pc_load_o      = ctrl.pc_load;
    assign if_id_load_o   = ctrl.if_id_load;
    assign id_ex_load_o   = ctrl.id_ex_load;
    assign ex_mem_load_o  = ctrl.ex_mem_load;
    assign mem_wb_load_o  = ctrl.mem_wb_load;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_flush_o = ctrl.ex_mem_flush;
    assign mem_wb_flush_o = ctrl.mem_wb_flush;
    assign mem_stall_o    = ctrl.mem_stall;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_counters u_perf (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (stall),
        .bubble_i         (bubble),
        .flush_i          (redirect),
        .perf_stall_cyc_o (perf_stall_cyc_o),
        .perf_bubble_o    (perf_bubble_o),
        .perf_flush_o     (perf_flush_o)
    );
`else
    assign perf_stall_cyc_o = 32'd0;
    assign perf_bubble_o    = 32'd0;
    assign perf_flush_o     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl with a cycle model
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_read, imem_resp, dmem_access, dmem_resp;
    logic        ex_redirect, ex_mem_read;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_rs1_use, id_rs2_use;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_stall;
    logic [31:0] perf_stall, perf_bubble, perf_flush;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: which memory sides have answered inside the current stall, and event counts
    bit          m_i_seen, m_d_seen;
    logic [31:0] m_stall_cnt, m_bubble_cnt, m_flush_cnt;
    logic [9:0]  exp_v, act_v;
    bit          m_wi, m_wd, m_st, m_hz;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .imem_read_i      (imem_read),
        .imem_resp_i      (imem_resp),
        .dmem_access_i    (dmem_access),
        .dmem_resp_i      (dmem_resp),
        .ex_redirect_i    (ex_redirect),
        .ex_mem_read_i    (ex_mem_read),
        .ex_rd_i          (ex_rd),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_rs1_use_i     (id_rs1_use),
        .id_rs2_use_i     (id_rs2_use),
        .pc_load_o        (pc_load),
        .if_id_load_o     (if_id_load),
        .id_ex_load_o     (id_ex_load),
        .ex_mem_load_o    (ex_mem_load),
        .mem_wb_load_o    (mem_wb_load),
        .if_id_flush_o    (if_id_flush),
        .id_ex_flush_o    (id_ex_flush),
        .ex_mem_flush_o   (ex_mem_flush),
        .mem_wb_flush_o   (mem_wb_flush),
        .mem_stall_o      (mem_stall),
        .perf_stall_cyc_o (perf_stall),
        .perf_bubble_o    (perf_bubble),
        .perf_flush_o     (perf_flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle model comparison: outputs {pc, loads, flushes, mem_stall} and counters.
    always @(negedge clk) begin
        act_v = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_stall};
        if (!rst_ni) begin
            exp_v        = 10'b0;
            m_i_seen     = 1'b0;
            m_d_seen     = 1'b0;
            m_stall_cnt  = 32'd0;
            m_bubble_cnt = 32'd0;
            m_flush_cnt  = 32'd0;
            m_st         = 1'b0;
            m_hz         = 1'b0;
        end else begin
            m_wi = imem_read && !imem_resp && !m_i_seen;
            m_wd = dmem_access && !dmem_resp && !m_d_seen;
            m_st = m_wi || m_wd;
            m_hz = ex_mem_read && (ex_rd != 0) &&
                   ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
            if (m_st)             exp_v = 10'b0000000011;
            else if (ex_redirect) exp_v = 10'b1111111000;
            else if (m_hz)        exp_v = 10'b0001101000;
            else                  exp_v = 10'b1111100000;
        end
        check("ctrl_vector", {22'd0, act_v}, {22'd0, exp_v});
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", perf_stall, m_stall_cnt);
        check("perf_bubble", perf_bubble, m_bubble_cnt);
        check("perf_flush", perf_flush, m_flush_cnt);
`else
        check("perf_tied", perf_stall | perf_bubble | perf_flush, 32'd0);
`endif
        if (rst_ni) begin
            if (m_st) begin
                m_i_seen    = m_i_seen || imem_resp;
                m_d_seen    = m_d_seen || dmem_resp;
                m_stall_cnt = m_stall_cnt + 1;
            end else begin
                m_i_seen = 1'b0;
                m_d_seen = 1'b0;
                if (ex_redirect) m_flush_cnt = m_flush_cnt + 1;
                else if (m_hz)   m_bubble_cnt = m_bubble_cnt + 1;
            end
        end
    end

    task automatic idle_inputs();
        imem_read = 0; imem_resp = 0; dmem_access = 0; dmem_resp = 0;
        ex_redirect = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_use = 0; id_rs2_use = 0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        adv(); adv();
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        check("rst_if_id_load", {31'd0, if_id_load}, 32'd0);
        rst_ni = 1'b1;
        settle();
        check("idle_pc_load", {31'd0, pc_load}, 32'd1);
        check("idle_loads", {28'd0, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}, 32'hF);
        check("idle_flushes", {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, 32'd0);
        adv();

        // split response: imem answers at cycle 2, dmem at cycle 5
        for (int c = 0; c < 6; c++) begin
            imem_read = 1; dmem_access = 1;
            imem_resp = (c == 2); dmem_resp = (c == 5);
            settle();
            check($sformatf("split_stall_c%0d", c), {31'd0, mem_stall}, (c < 5) ? 32'd1 : 32'd0);
            check($sformatf("split_wbflush_c%0d", c), {31'd0, mem_wb_flush}, (c < 5) ? 32'd1 : 32'd0);
            adv();
        end
        dmem_access = 0; dmem_resp = 0; imem_resp = 0;
        settle();
        check("split_flags_cleared", {31'd0, mem_stall}, 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        check("split_perf_stall", perf_stall, 32'd5);
`endif
        adv();
        imem_resp = 1;
        settle();
        check("split_done_advance", {31'd0, pc_load}, 32'd1);
        adv();
        idle_inputs();

`ifdef PIPE_CTRL_PERF_EN
        force dut.u_perf.stall_cyc_q = 32'hFFFF_FFFF;
        m_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.stall_cyc_q;
        dmem_access = 1;
        settle();
        adv();
        dmem_resp = 1;
        settle();
        check("perf_wrap", perf_stall, 32'd0);
        adv();
        idle_inputs();
`endif

        // load-use via rs2, then same with x0 destination
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_use = 1;
        settle();
        check("lu_pc_load", {31'd0, pc_load}, 32'd0);
        check("lu_if_id_load", {31'd0, if_id_load}, 32'd0);
        check("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        check("lu_ex_mem_load", {31'd0, ex_mem_load}, 32'd1);
        adv();
        ex_rd = 0; id_rs2 = 0;
        settle();
        check("lu_x0_pc_load", {31'd0, pc_load}, 32'd1);
        check("lu_x0_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
        adv();
        ex_rd = 12; id_rs1 = 12; id_rs1_use = 1; id_rs2_use = 0; id_rs2 = 3;
        settle();
        check("lu_rs1_bubble", {31'd0, id_ex_flush}, 32'd1);
        adv();
        id_rs1_use = 0;
        settle();
        check("lu_rs1_unused", {31'd0, id_ex_flush}, 32'd0);
        adv();

        // redirect with a load-use hazard present: redirect wins
        id_rs1_use = 1; ex_redirect = 1;
        settle();
        check("rd_lu_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        check("rd_lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        check("rd_lu_pc_load", {31'd0, pc_load}, 32'd1);
        adv();
        idle_inputs();

        // redirect held through a 3-cycle dmem stall
        for (int c = 0; c < 4; c++) begin
            ex_redirect = 1; dmem_access = 1; dmem_resp = (c == 3);
            settle();
            check($sformatf("rd_stall_if_id_flush_c%0d", c), {31'd0, if_id_flush}, (c == 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_stall_id_ex_flush_c%0d", c), {31'd0, id_ex_flush}, (c == 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_stall_wb_flush_c%0d", c), {31'd0, mem_wb_flush}, (c == 3) ? 32'd0 : 32'd1);
            adv();
        end
        idle_inputs();

        // reset asserted mid-stall after imem has answered
        imem_read = 1; dmem_access = 1; imem_resp = 1;
        settle();
        adv();
        imem_resp = 0;
        rst_ni = 1'b0;
        #2;
        check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_mid_wb_flush", {31'd0, mem_wb_flush}, 32'd0);
        adv();
        rst_ni = 1'b1;
        dmem_access = 0;
        settle();
        check("rst_clean_flags", {31'd0, mem_stall}, 32'd1);
        adv();
        imem_resp = 1;
        settle();
        check("rst_post_advance", {31'd0, pc_load}, 32'd1);
        adv();
        idle_inputs();
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
